encrypt_arbiter: RTL and testbench

Shares one Encrypt AEAD core among NREQ requesters using round-robin arbitration.
- Latches the winning requester's nonce, associated data and plaintext.
- Holds the shared 448-bit key register.
- Pulses the core start, waits for done, and returns the ciphertext and tag to the granted requester.
- Sits between the requester ports and the single Encrypt instance.

---
 rtl/encrypt_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_encrypt_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_arbiter.sv
// ---------------------------------------------------------------------------
// encrypt_arbiter
//
// Shares a single Encrypt AEAD core among NREQ requesters with round-robin
// arbitration. The winner's nonce / associated data / plaintext are latched
// into operand registers, the core is started with a one-cycle pulse, and
// the ciphertext and tag are returned to the granted requester once the
// core signals completion. A shared KW-bit key register is written through
// key_we/key_in while the arbiter is idle.
//
// Optional build macro:
//   ENC_ARB_TIMEOUT_EN - abort an operation whose core_done edge does not
//                        arrive within TIMEOUT WAIT cycles (resp_err=1,
//                        resp_c=0, one-cycle core_rst pulse). Without it
//                        WAIT waits indefinitely and resp_err is tied to 0.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   key_we, key_in     key register write (ignored while key_busy)
//   key_busy           high whenever the FSM is not IDLE
//   req                per-requester request levels
//   req_nonce/a/p      packed operands, requester i at [i*DW +: DW]
//   grant              one-hot grant, held from launch through response
//   resp_valid         one-cycle result strobe
//   resp_c, resp_tag   captured ciphertext and tag (held until next capture)
//   resp_err           result aborted by timeout, qualified by resp_valid
//   core_rst           active-high core reset
//   core_start         one-cycle start pulse to the core
//   core_k             key register contents
//   core_nonce/a/p     latched operands
//   core_done          core completion (level may stay high)
//   core_c, core_tag   core results
// ---------------------------------------------------------------------------
module encrypt_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 128,
    parameter int KW      = 448,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_we,
    input  logic [KW-1:0]        key_in,
    output logic                 key_busy,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_nonce,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_p,
    output logic [NREQ-1:0]      grant,
    output logic                 resp_valid,
    output logic [DW-1:0]        resp_c,
    output logic                 resp_tag,
    output logic                 resp_err,
    output logic                 core_rst,
    output logic                 core_start,
    output logic [KW-1:0]        core_k,
    output logic [DW-1:0]        core_nonce,
    output logic [DW-1:0]        core_a,
    output logic [DW-1:0]        core_p,
    input  logic                 core_done,
    input  logic [DW-1:0]        core_c,
    input  logic                 core_tag
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q;
    logic [IW-1:0]     gidx_q;
    logic [IW-1:0]     rr_q;
    logic [KW-1:0]     key_q;
    logic [DW-1:0]     nonce_q, a_q, p_q;
    logic [DW-1:0]     c_q;
    logic              tag_q;
    logic              done_q;
    logic              core_rst_q;
    logic              rst_hold_q;

    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic [IW:0]       cand;
    logic [NREQ-1:0]   pick_onehot;
    logic [DW-1:0]     sel_nonce, sel_a, sel_p;
    logic [IW-1:0]     rr_next;

    logic              done_edge;
    logic              launch;
    logic              capture;
    logic              abort;

    // Only a fresh rising edge counts; a level left high by a previous
    // operation is ignored until it drops and rises again.
    assign done_edge = core_done & ~done_q;

    // Round-robin search: first set request bit at or after rr_q, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!pick_vld && req[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    // Operand and grant selection for the winning requester.
    always_comb begin
        pick_onehot = '0;
        sel_nonce   = '0;
        sel_a       = '0;
        sel_p       = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == IW'(k)) begin
                pick_onehot[k] = 1'b1;
                sel_nonce      = req_nonce[k*DW +: DW];
                sel_a          = req_a[k*DW +: DW];
                sel_p          = req_p[k*DW +: DW];
            end
        end
    end

    assign rr_next = (gidx_q == IW'(NREQ-1)) ? '0 : gidx_q + 1'b1;

`ifdef ENC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_q;
    logic          err_q;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    launch  = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A done edge wins over a timeout hitting the same cycle.
                if (done_edge) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
`ifdef ENC_ARB_TIMEOUT_EN
                else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, key and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_q       <= '0;
            key_q      <= '0;
            nonce_q    <= '0;
            a_q        <= '0;
            p_q        <= '0;
            c_q        <= '0;
            tag_q      <= 1'b0;
            done_q     <= 1'b0;
            rst_hold_q <= 1'b1;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            done_q     <= core_done;
            rst_hold_q <= 1'b0;
            // Keeps the core in reset for one cycle after release, and
            // pulses it after an aborted operation.
            core_rst_q <= rst_hold_q | abort;

            // Key write lands on the same edge as a launch, so the core
            // already sees the new key during LAUNCH.
            if (state_q == IDLE && key_we) begin
                key_q <= key_in;
            end

            if (launch) begin
                grant_q <= pick_onehot;
                gidx_q  <= pick_idx;
                nonce_q <= sel_nonce;
                a_q     <= sel_a;
                p_q     <= sel_p;
            end

            if (capture) begin
                c_q   <= core_c;
                tag_q <= core_tag;
            end else if (abort) begin
                c_q   <= '0;
            end

            if (state_q == RESP) begin
                grant_q <= '0;
                rr_q    <= rr_next;
            end
        end
    end

`ifdef ENC_ARB_TIMEOUT_EN
    // WAIT cycle counter and abort flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == LAUNCH) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (capture) begin
                err_q <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign key_busy   = (state_q != IDLE);
    assign grant      = grant_q;
    assign resp_valid = (state_q == RESP);
    assign resp_c     = c_q;
    assign resp_tag   = tag_q;
    assign core_rst   = core_rst_q;
    assign core_start = (state_q == LAUNCH);
    assign core_k     = key_q;
    assign core_nonce = nonce_q;
    assign core_a     = a_q;
    assign core_p     = p_q;

endmodule

// File: tb/tb_encrypt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_encrypt_arbiter
//
// Scoreboard bench for encrypt_arbiter. The stimulus side predicts which
// requester must win next (round-robin search over the request vector it
// drives) and what the core must return for that requester's operands and
// the key the bench believes is loaded; a separate monitor pops those
// predictions whenever the DUT launches or responds. A behavioural core
// model answers core_start with a configurable delay, may hold core_done
// high across operations, or may never answer (timeout / abort cases).
// ---------------------------------------------------------------------------
module tb_encrypt_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 128;
    localparam int KW   = 448;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 key_we = 1'b0;
    logic [KW-1:0]        key_in = '0;
    logic                 key_busy;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   req_nonce, req_a, req_p;
    logic [NREQ-1:0]      grant;
    logic                 resp_valid;
    logic [DW-1:0]        resp_c;
    logic                 resp_tag;
    logic                 resp_err;
    logic                 core_rst;
    logic                 core_start;
    logic [KW-1:0]        core_k;
    logic [DW-1:0]        core_nonce, core_a, core_p;
    logic                 core_done;
    logic [DW-1:0]        core_c;
    logic                 core_tag;

    logic [DW-1:0] tn [NREQ];
    logic [DW-1:0] ta [NREQ];
    logic [DW-1:0] tp [NREQ];

    encrypt_arbiter #(.NREQ(NREQ), .DW(DW), .KW(KW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .key_we(key_we), .key_in(key_in),
        .key_busy(key_busy), .req(req), .req_nonce(req_nonce),
        .req_a(req_a), .req_p(req_p), .grant(grant),
        .resp_valid(resp_valid), .resp_c(resp_c), .resp_tag(resp_tag),
        .resp_err(resp_err), .core_rst(core_rst), .core_start(core_start),
        .core_k(core_k), .core_nonce(core_nonce), .core_a(core_a),
        .core_p(core_p), .core_done(core_done), .core_c(core_c),
        .core_tag(core_tag)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_nonce = '0;
        req_a     = '0;
        req_p     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_nonce[i*DW +: DW] = tn[i];
            req_a[i*DW +: DW]     = ta[i];
            req_p[i*DW +: DW]     = tp[i];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_evt(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    // Abstract core function: any deterministic mix of operands and key.
    function automatic logic [DW-1:0] enc_f(input logic [DW-1:0] n, input logic [DW-1:0] a,
                                            input logic [DW-1:0] p, input logic [KW-1:0] k);
        return n ^ {a[63:0], a[127:64]} ^ (p + k[127:0]) ^ k[447:320];
    endfunction

    function automatic logic tag_f(input logic [DW-1:0] n, input logic [DW-1:0] a,
                                   input logic [DW-1:0] p, input logic [KW-1:0] k);
        return (^(n & a)) ^ (^p) ^ k[0] ^ k[447];
    endfunction

    function automatic logic [DW-1:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [DW-1:0] FORCED_C = {16{8'hA5}};

    // ------------------------------------------------------------------
    // Core model
    // ------------------------------------------------------------------
    bit          no_done   = 1'b0;
    bit          force_c   = 1'b0;
    int          hold_mode = 0;    // 0 pulse, 1 random hold, 2 always hold
    int          fixed_dly = 0;
    int          rise_cyc  = -100;

    initial begin : core_model
        bit            cbusy;
        bit            chold;
        int            ccnt, cdrop, ctarget;
        logic [DW-1:0] cres;
        logic          ctag;
        cbusy = 1'b0; chold = 1'b0; ccnt = 0; cdrop = -1; ctarget = 0;
        cres = '0; ctag = 1'b0;
        core_done = 1'b0; core_c = '0; core_tag = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (core_rst) begin
                core_done = 1'b0;
                cbusy     = 1'b0;
                chold     = 1'b0;
            end else if (core_start) begin
                cbusy = 1'b1;
                ccnt  = 0;
                cres  = force_c ? FORCED_C : enc_f(core_nonce, core_a, core_p, core_k);
                ctag  = tag_f(core_nonce, core_a, core_p, core_k);
                if (core_done) begin
                    cdrop   = $urandom_range(1, 3);
                    ctarget = cdrop + $urandom_range(1, 4);
                end else begin
                    cdrop   = -1;
                    ctarget = (fixed_dly > 0) ? fixed_dly : $urandom_range(2, 25);
                end
            end else if (cbusy) begin
                ccnt++;
                if (ccnt == cdrop) core_done = 1'b0;
                if (ccnt == ctarget && !no_done) begin
                    core_done = 1'b1;
                    core_c    = cres;
                    core_tag  = ctag;
                    rise_cyc  = cyc;
                    cbusy     = 1'b0;
                    chold     = (hold_mode == 2) || (hold_mode == 1 && $urandom_range(0, 1) == 1);
                end
            end else if (core_done && !chold) begin
                core_done = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model / scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int            idx;
        logic [DW-1:0] c;
        logic          tag;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            m_rr     = 0;
    int            last_idx = 0;
    logic [KW-1:0] tb_key   = '0;

    task automatic push_expect();
        exp_t e;
        int   j;
        e.idx = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_rr + k) % NREQ;
            if (e.idx < 0 && req[j]) e.idx = j;
        end
        e.c   = force_c ? FORCED_C : enc_f(tn[e.idx], ta[e.idx], tp[e.idx], tb_key);
        e.tag = tag_f(tn[e.idx], ta[e.idx], tp[e.idx], tb_key);
        e.err = no_done;
        if (no_done) e.c = '0;
        sb.push_back(e);
        last_idx = e.idx;
        m_rr     = (e.idx + 1) % NREQ;
    endtask

    task automatic raise(input int i);
        req[i] = 1'b1;
        tn[i]  = r128();
        ta[i]  = r128();
        tp[i]  = r128();
    endtask

    task automatic start(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) raise(k);
        push_expect();
    endtask

    task automatic wait_resp(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < budget);
        if (!resp_valid) fail_evt("resp_wait_expired");
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (!core_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!core_start) fail_evt("start_wait_expired");
    endtask

    // mode 0: drop served; 1: served requester re-raises at once;
    // 2: drop served and randomly raise idle requesters.
    task automatic serve(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            wait_resp(300);
            if (i == n - 1) begin
                req = '0;
            end else begin
                if (mode == 1) begin
                    raise(last_idx);
                end else begin
                    req[last_idx] = 1'b0;
                    if (mode == 2) begin
                        for (int k = 0; k < NREQ; k++)
                            if (!req[k] && $urandom_range(0, 2) == 0) raise(k);
                    end
                end
                if (req == '0) raise($urandom_range(0, NREQ - 1));
                push_expect();
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int   n_start   = 0;
    int   start_cyc = -100;
    exp_t mon_e;
    logic [NREQ-1:0] mon_oh;

    always @(negedge clk) begin
        if (!rst) begin
            n_start = 0;
        end else begin
            if (core_start) begin
                n_start++;
                start_cyc = cyc;
                if (sb.size() == 0) begin
                    fail_evt("unexpected_core_start");
                end else begin
                    mon_oh = '0;
                    mon_oh[sb[0].idx] = 1'b1;
                    chk("start_grant", grant, mon_oh);
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    fail_evt("unexpected_resp_valid");
                end else begin
                    mon_e  = sb.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.idx] = 1'b1;
                    chk("resp_grant", grant, mon_oh);
                    chk("resp_err", resp_err, mon_e.err);
                    chk("resp_c", resp_c, mon_e.c);
                    chk("starts_per_op", n_start, 1);
                    if (mon_e.err) begin
                        chk("timeout_latency", cyc, start_cyc + TO + 1);
                        chk("timeout_core_rst", core_rst, 1'b1);
                    end else begin
                        chk("resp_tag", resp_tag, mon_e.tag);
                        chk("done_latency", cyc, rise_cyc + 1);
                    end
                end
                n_start = 0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [KW-1:0] K1 = 448'h75686577667569686875666f656969;
    localparam logic [DW-1:0] N1 = 128'h64646f6e277420726561642074686973;

    initial begin : stim
        logic [KW-1:0] k2;
        for (int i = 0; i < NREQ; i++) begin
            tn[i] = '0; ta[i] = '0; tp[i] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, '0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_key_busy", key_busy, 1'b0);
        chk("rst_resp_c", resp_c, '0);
        chk("rst_resp_tag", resp_tag, 1'b0);
        chk("rst_core_k", core_k, '0);
        chk("rst_core_nonce", core_nonce, '0);
        chk("rst_core_rst", core_rst, 1'b1);

        // Release with a key write in the first cycle
        rst = 1'b1; key_we = 1'b1; key_in = K1; tb_key = K1;
        @(negedge clk);
        key_we = 1'b0;
        chk("post_rel_core_rst", core_rst, 1'b1);
        chk("key_load", core_k, K1);
        @(negedge clk);
        chk("core_rst_released", core_rst, 1'b0);

        // Round-robin with all requesters held
        start(4'b1111);
        serve(5, 1);

        // Single request with fixed core latency and forced result
        @(negedge clk);
        force_c = 1'b1; fixed_dly = 20;
        raise(1);
        tn[1] = N1;
        push_expect();
        @(negedge clk);
        chk("single_grant", grant, 4'b0010);
        chk("single_core_start", core_start, 1'b1);
        chk("single_key_busy", key_busy, 1'b1);
        chk("single_core_nonce", core_nonce, N1);
        wait_resp(100);
        req = '0;
        force_c = 1'b0; fixed_dly = 0;

        // Held done: the second op must wait for a fresh rising edge
        hold_mode = 2;
        @(negedge clk);
        start(4'b0001);
        serve(3, 0);
        hold_mode = 0;

        // Key write during WAIT is ignored
        fixed_dly = 10;
        @(negedge clk);
        start(4'b0100);
        wait_start(20);
        key_we = 1'b1; key_in = '0;
        repeat (3) begin
            @(negedge clk);
            chk("key_protect", core_k, tb_key);
        end
        key_we = 1'b0;
        wait_resp(100);
        req = '0;

        // Key write in IDLE together with a request: launch uses new key
        @(negedge clk);
        k2 = {r128(), r128(), r128(), r128()};
        key_we = 1'b1; key_in = k2; tb_key = k2;
        start(4'b1000);
        @(negedge clk);
        key_we = 1'b0;
        chk("key_idle_write", core_k, k2);
        wait_resp(100);
        req = '0;
        fixed_dly = 0;

        // Randomised traffic
        hold_mode = 1;
        @(negedge clk);
        start(4'($urandom_range(1, 15)));
        serve(60, 2);
        hold_mode = 0;

`ifdef ENC_ARB_TIMEOUT_EN
        // Core never answers: abort, then a normal op
        no_done = 1'b1;
        @(negedge clk);
        start(4'b1000);
        wait_resp(100);
        req = '0;
        no_done = 1'b0;
        @(negedge clk);
        chk("timeout_core_rst_single", core_rst, 1'b0);
        start(4'b0010);
        wait_resp(100);
        req = '0;
`endif

        // Reset during an operation
        no_done = 1'b1;
        @(negedge clk);
        start(4'b0010);
        wait_start(20);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_grant", grant, '0);
        chk("midrst_key_busy", key_busy, 1'b0);
        chk("midrst_resp_valid", resp_valid, 1'b0);
        chk("midrst_core_rst", core_rst, 1'b1);
        chk("midrst_core_k", core_k, '0);
        chk("midrst_resp_c", resp_c, '0);
        sb.delete();
        req = '0;
        rst = 1'b1;
        m_rr = 0; tb_key = '0; no_done = 1'b0;
        repeat (3) @(negedge clk);
        start(4'b1111);
        serve(2, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
